// File: rtl/mips_bus_controller.sv
// rtl/mips_bus_controller.sv - arbitrates MIPS fetch and data requests onto one Avalon-MM master port
module mips_bus_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  input  logic        halt_req,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        fetch_done,
  output logic        data_done,
  output logic [31:0] rdata,
  output logic        active,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  stall_q, stall_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        fetch_done_q, fetch_done_d;
  logic        data_done_q, data_done_d;
  logic        active_q, active_d;
  logic        bus_error_q, bus_error_d;

  logic        data_go, fetch_go, busy, timeout;
  logic        unused_addr_lsbs;

  // A requester still sees its own done pulse this cycle and has not yet dropped
  // its request, so that request must not be accepted a second time.
  assign data_go  = data_req && !data_done_q;
  assign fetch_go = fetch_req && !fetch_done_q;
  assign busy     = (state_q == FETCH) || (state_q == DATA);
  assign timeout  = busy && waitrequest && (stall_q == 8'd254);

  assign unused_addr_lsbs = ^{fetch_addr[1:0], data_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      stall_q      <= 8'd0;
      address_q    <= 32'd0;
      writedata_q  <= 32'd0;
      rdata_q      <= 32'd0;
      byteenable_q <= 4'b0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      active_q     <= 1'b1;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rdata_q      <= rdata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      active_q     <= active_d;
      bus_error_q  <= bus_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt_req)      state_d = HALTED;
        else if (data_go)  state_d = DATA;
        else if (fetch_go) state_d = FETCH;
      end
      FETCH, DATA: begin
        if (!waitrequest)  state_d = IDLE;
        else if (timeout)  state_d = HALTED;
      end
      default:             state_d = HALTED;
    endcase
  end

  always_comb begin
    stall_d      = stall_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    rdata_d      = rdata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    bus_error_d  = bus_error_q;
    active_d     = (state_d != HALTED);
    case (state_q)
      IDLE: begin
        if (!halt_req && data_go) begin
          address_d    = {data_addr[31:2], 2'b00};
          byteenable_d = data_byteenable;
          writedata_d  = data_writedata;
          read_d       = !data_write;
          write_d      = data_write;
          stall_d      = 8'd0;
        end else if (!halt_req && fetch_go) begin
          address_d    = {fetch_addr[31:2], 2'b00};
          byteenable_d = 4'b1111;
          read_d       = 1'b1;
          write_d      = 1'b0;
          stall_d      = 8'd0;
        end
      end
      FETCH, DATA: begin
        if (!waitrequest) begin
          if (read_q) rdata_d = readdata;
          read_d       = 1'b0;
          write_d      = 1'b0;
          fetch_done_d = (state_q == FETCH);
          data_done_d  = (state_q == DATA);
        end else if (timeout) begin
          // Slave never answered: abandon the access and stop for good.
          read_d      = 1'b0;
          write_d     = 1'b0;
          bus_error_d = 1'b1;
          stall_d     = 8'd255;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign fetch_done = fetch_done_q;
  assign data_done  = data_done_q;
  assign rdata      = rdata_q;
  assign active     = active_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mips_bus_controller.sv
// tb/tb_mips_bus_controller.sv - randomized transaction-level bench for mips_bus_controller
module tb_mips_bus_controller;

  logic        clk = 1'b0;
  logic        reset_n, fetch_req, data_req, data_write, halt_req, waitrequest;
  logic [31:0] fetch_addr, data_addr, data_writedata, readdata;
  logic [3:0]  data_byteenable;
  logic [31:0] address, writedata, rdata;
  logic [3:0]  byteenable;
  logic        read, write, fetch_done, data_done, active, bus_error;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  mips_bus_controller dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .halt_req(halt_req),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .fetch_done(fetch_done), .data_done(data_done), .rdata(rdata),
    .active(active), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0; halt_req = 1'b0; waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    m_rdata = 32'd0;
    tick();
  endtask

  // Expected behaviour is a schedule: data (if any) goes first starting cycle 1,
  // each access lasts 1+waits cycles, done follows one cycle later, and a queued
  // fetch starts the cycle after the data done pulse.
  task automatic run_pair(input bit do_f, input bit do_d, input logic [31:0] fa,
                          input logic [31:0] da, input bit dw, input logic [3:0] be,
                          input logic [31:0] wd, input int wf, input int wdt,
                          input logic [31:0] rdv, input int halt_at);
    int s[2], w[2], n, last_done;
    bit isd[2], isw[2];
    logic [31:0] ea[2], ewd[2], rd[2];
    logic [3:0] ebe[2];
    n = 0;
    if (do_d) begin
      isd[n] = 1; isw[n] = dw; ea[n] = {da[31:2], 2'b00}; ebe[n] = be; ewd[n] = wd; w[n] = wdt; n++;
    end
    if (do_f) begin
      isd[n] = 0; isw[n] = 0; ea[n] = {fa[31:2], 2'b00}; ebe[n] = 4'hF; ewd[n] = 32'd0; w[n] = wf; n++;
    end
    rd[0] = rdv; rd[1] = $urandom;
    s[0] = 1;
    s[1] = s[0] + w[0] + 2;
    last_done = s[n-1] + w[n-1] + 1;
    fetch_req = do_f; fetch_addr = fa;
    data_req = do_d; data_addr = da; data_write = dw; data_byteenable = be; data_writedata = wd;
    for (int c = 1; c <= last_done + 1; c++) begin
      bit er, ew, efd, edd;
      int act;
      tick();
      if (c == halt_at) halt_req = 1'b1;
      er = 0; ew = 0; efd = 0; edd = 0; act = -1;
      for (int i = 0; i < n; i++) begin
        if (c >= s[i] && c <= s[i] + w[i]) begin act = i; er = !isw[i]; ew = isw[i]; end
        if (c == s[i] + w[i] + 1) begin
          if (isd[i]) edd = 1; else efd = 1;
          if (!isw[i]) m_rdata = rd[i];
        end
      end
      check("read", read, er);
      check("write", write, ew);
      check("fetch_done", fetch_done, efd);
      check("data_done", data_done, edd);
      check("rdata", rdata, m_rdata);
      check("active", active, !(halt_at > 0 && c > last_done));
      if (act >= 0) begin
        check("address", address, ea[act]);
        check("byteenable", byteenable, ebe[act]);
        if (isw[act]) check("writedata", writedata, ewd[act]);
        waitrequest = (c < s[act] + w[act]);
        readdata = rd[act];
        // Inputs of the in-flight access may wander while it stalls.
        if (waitrequest && isd[act]) begin
          data_req = $urandom_range(0, 1);
          data_addr = $urandom; data_writedata = $urandom; data_byteenable = $urandom;
        end
        if (waitrequest && !isd[act]) fetch_req = $urandom_range(0, 1);
      end else begin
        waitrequest = $urandom_range(0, 1);
        readdata = $urandom;
      end
      if (efd) fetch_req = 1'b0;
      if (edd) data_req = 1'b0;
    end
    fetch_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    bit seen_done;
    reset_n = 1'b0; fetch_req = 1'b0; data_req = 1'b0; halt_req = 1'b0; waitrequest = 1'b0;
    data_write = 1'b0; fetch_addr = 32'd0; data_addr = 32'd0; data_byteenable = 4'd0;
    data_writedata = 32'd0; readdata = 32'd0; m_rdata = 32'd0;
    tick();
    tick();
    check("rst_address", address, 32'd0);
    check("rst_rw", {read, write, fetch_done, data_done, bus_error}, 5'd0);
    check("rst_be", byteenable, 4'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_active", active, 1'b1);
    reset_n = 1'b1;
    tick();

    run_pair(1, 0, 32'hBFC00003, 32'd0, 0, 4'd0, 32'd0, 0, 0, 32'h24020005, 0);
    run_pair(1, 1, 32'h00400010, 32'h00001004, 0, 4'b0011, 32'd0, 0, 0, 32'h11223344, 0);
    run_pair(0, 1, 32'd0, 32'h00002008, 1, 4'hF, 32'hDEADBEEF, 0, 5, 32'd0, 0);

    for (int k = 0; k < 40; k++) begin
      bit f, d;
      f = $urandom_range(0, 1); d = $urandom_range(0, 1);
      if (!f && !d) f = 1;
      run_pair(f, d, $urandom, $urandom, $urandom_range(0, 1), $urandom, $urandom,
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom, 0);
    end

    // Halt raised during a stalled load
    run_pair(0, 1, 32'd0, 32'h00003000, 0, 4'hF, 32'd0, 0, 3, 32'hCAFEF00D, 2);
    fetch_req = 1'b1; fetch_addr = 32'h00000100;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("halt_read", read, 1'b0);
      check("halt_fetch_done", fetch_done, 1'b0);
      check("halt_active", active, 1'b0);
    end
    do_reset();

    // Reset while a read is outstanding
    fetch_req = 1'b1; fetch_addr = 32'h00000200; waitrequest = 1'b1;
    tick();
    check("mid_read", read, 1'b1);
    tick();
    reset_n = 1'b0; fetch_req = 1'b0;
    tick();
    check("mr_read", read, 1'b0);
    check("mr_done", {fetch_done, data_done}, 2'b00);
    check("mr_address", address, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    check("mr_active", active, 1'b1);
    reset_n = 1'b1; m_rdata = 32'd0; waitrequest = 1'b0;
    tick();
    run_pair(1, 0, 32'h00000204, 32'd0, 0, 4'd0, 32'd0, 1, 0, 32'h0BADC0DE, 0);

    // Stall timeout on a fetch
    fetch_req = 1'b1; fetch_addr = 32'h00000300; waitrequest = 1'b1;
    seen_done = 0;
    for (int c = 1; c <= 255; c++) begin
      tick();
      if (fetch_done) seen_done = 1;
      if (c == 1) check("to_read_start", read, 1'b1);
    end
    check("to_read_254", read, 1'b1);
    check("to_err_254", bus_error, 1'b0);
    tick();
    check("to_err", bus_error, 1'b1);
    check("to_read", read, 1'b0);
    check("to_active", active, 1'b0);
    waitrequest = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (fetch_done) seen_done = 1;
    end
    check("to_no_done", seen_done, 1'b0);
    check("to_err_sticky", bus_error, 1'b1);
    check("to_read_after", read, 1'b0);
    check("to_active_after", active, 1'b0);
    do_reset();
    check("post_err_clear", bus_error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_controller.md
MIPS_BUS_CONTROLLER -- requirements
Module: mips_bus_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- fetch_req  in  1  instruction fetch request; held by the requester until fetch_done.
- fetch_addr  in  32  fetch byte address.
- data_req  in  1  data access request; held by the requester until data_done.
- data_write  in  1  1 = store, 0 = load.
- data_addr  in  32  data byte address.
- data_byteenable  in  4  lane enables for the data access.
- data_writedata  in  32  store data.
- halt_req  in  1  enter HALTED when idle.
- address  out  32  Avalon address.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- byteenable  out  4  Avalon byteenable.
- writedata  out  32  Avalon writedata.
- readdata  in  32  Avalon readdata; valid in a cycle with read=1 and waitrequest=0.
- waitrequest  in  1  Avalon stall.
- fetch_done  out  1  one-cycle pulse: fetch complete.
- data_done  out  1  one-cycle pulse: data access complete.
- rdata  out  32  last captured readdata.
- active  out  1  high when state != HALTED.
- bus_error  out  1  sticky stall-timeout flag.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: IDLE=0, FETCH=1, DATA=2, HALTED=3.
REQ-005 IDLE priority SHALL be: halt_req -> HALTED; else data_req -> DATA; else fetch_req -> FETCH; else stay in IDLE.
REQ-006 When data_req and fetch_req are high together, DATA SHALL win; the fetch SHALL remain pending and be served on a later IDLE cycle.
REQ-007 On acceptance, address/byteenable/writedata and read or write SHALL be driven from the next cycle, as follows:
- FETCH: address = {fetch_addr[31:2],2'b00}, byteenable = 1111, read = 1.
- DATA: address = {data_addr[31:2],2'b00}, byteenable = data_byteenable, read = !data_write, write = data_write.
REQ-008 While waitrequest=1 in FETCH or DATA, all Avalon outputs SHALL be held constant; request inputs SHALL be ignored, including deassertion.
REQ-009 In the first FETCH/DATA cycle with waitrequest=0, the transaction SHALL complete, with the following effects on the next cycle:
- rdata captures readdata (reads only; writes leave rdata unchanged).
- read and write go to 0.
- The matching *_done pulses for exactly one cycle.
- The state returns to IDLE.
REQ-010 Minimum latency with zero wait states SHALL be: request seen in cycle 0, read/write high in cycle 1, done in cycle 2. The next request SHALL be accepted no earlier than cycle 2.
REQ-011 An 8-bit stall counter SHALL behave as follows:
- Cleared on every acceptance.
- Incremented each FETCH/DATA cycle with waitrequest=1.
- On reaching 255: bus_error is set, read and write are dropped, no done pulse is issued, and the state goes to HALTED.
REQ-012 halt_req asserted mid-transaction SHALL NOT abort the transaction; the halt SHALL be taken from IDLE after done.
REQ-013 HALTED SHALL be terminal: read=write=0, no done pulses, active=0, and requests ignored until reset.
REQ-014 At most one of read and write SHALL be high in any cycle, and at most one of fetch_done and data_done SHALL be high in any cycle.

Reset
REQ-015 With reset_n=0 sampled at a rising edge, the block SHALL set the following on that edge, regardless of any in-flight transaction:
- state = IDLE.
- address = 0, writedata = 0, rdata = 0, byteenable = 0000.
- read, write, fetch_done, data_done, bus_error = 0.
- Stall counter = 0.
- active = 1.
REQ-016 A transaction interrupted by reset SHALL produce no done pulse.

Verification
REQ-017 Single fetch, no wait: fetch_req, fetch_addr=0xBFC00003, waitrequest=0, readdata=0x24020005 -> cycle 1: address=0xBFC00000, read=1, byteenable=1111; cycle 2: fetch_done=1, rdata=0x24020005, read=0.
REQ-018 Conflict: fetch_req and data_req (load, addr 0x1004, be=0011) raised together -> data access first, data_done pulsed, then the fetch is issued; fetch_done follows data_done by 2 cycles.
REQ-019 Stalled store: data_write=1, data_writedata=0xDEADBEEF, waitrequest=1 for 5 cycles -> write, address and writedata held stable for all 5 cycles; data_done 1 cycle after waitrequest drops; rdata unchanged.
REQ-020 Timeout: waitrequest held 1 during a fetch -> after 255 stall cycles bus_error=1, read=0, active=0, no fetch_done; stays until reset.
REQ-021 Halt mid-access: halt_req raised during a 3-wait-state load -> data_done is still pulsed, then active=0 in the following cycle; a subsequent fetch_req is ignored.
REQ-022 Reset mid-access: reset_n=0 while read=1 -> next cycle read=0, no done pulse, state IDLE; after release a new fetch completes normally.
